// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Purpose  : Shared state encoding and default widths for the memory access
//             arbiter and its round-robin grant logic.
//  Revision : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

  // Transaction sequencer states: accept, drive memory, hand back response.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 32;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_access_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin pick. The winner is the first asserted
//             request strictly after ptr_i, wrapping; the pointer register
//             itself lives in the parent.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  // Scan from ptr+1 around to ptr itself; first hit wins.
  always_comb begin
    int cand;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(ptr_i) + k) % NUM_REQ;
      if (!valid_o && req_i[cand]) begin
        valid_o       = 1'b1;
        idx_o         = IDX_W'(cand);
        grant_o[cand] = 1'b1;
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/mem_access_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_arbiter
//  Purpose  : Round-robin arbiter placing NUM_REQ valid/ready requesters onto
//             a single-port memory, one transaction in flight at a time
//             (IDLE -> ACCESS -> RESP).
//  Revision : 1.0  initial release
// ============================================================================
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ-1:0]        req_write_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_rdata_o,
  input  logic [NUM_REQ-1:0]        rsp_ready_i,
  output logic                      mem_enable_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic [DATA_W-1:0]         mem_data_in_o,
  input  logic [DATA_W-1:0]         mem_data_out_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   owner_q;
  logic               wr_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q;

  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_grant_idx;
  logic               w_grant_vld;
  logic               w_accept;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req_i   (req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (w_grant),
    .idx_o   (w_grant_idx),
    .valid_o (w_grant_vld)
  );

  // Ready only mirrors a valid in IDLE, so acceptance is just "IDLE with a winner".
  assign w_accept = (state_q == IDLE) && w_grant_vld;

  // Memory address/data come straight from the latch, so they hold between accesses.
  assign mem_addr_o    = addr_q;
  assign mem_data_in_o = wdata_q;
  assign rsp_rdata_o   = rdata_q;

  // Next-state and handshake/strobe outputs.
  always_comb begin
    state_d      = state_q;
    req_ready_o  = '0;
    rsp_valid_o  = '0;
    mem_enable_o = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = w_grant;
        if (w_grant_vld) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_enable_o = wr_q;
        state_d      = RESP;
      end
      RESP: begin
        rsp_valid_o[owner_q] = 1'b1;
        if (rsp_ready_i[owner_q]) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; async reset kills any access so no write strobe survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latch, fairness pointer and response data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      owner_q <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (w_accept) begin
        ptr_q   <= w_grant_idx;
        owner_q <= w_grant_idx;
        wr_q    <= req_write_i[w_grant_idx];
        addr_q  <= req_addr_i[w_grant_idx*ADDR_W +: ADDR_W];
        wdata_q <= req_wdata_i[w_grant_idx*DATA_W +: DATA_W];
      end
      if (state_q == ACCESS) begin
        rdata_q <= wr_q ? '0 : mem_data_out_i;
      end
    end
  end

endmodule : mem_access_arbiter
`default_nettype wire

// File: tb/tb_mem_access_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_arbiter
//  Purpose  : Self-checking bench: behavioural 16x32 memory, reference model
//             of arbitration/sequencing and a response scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_access_arbiter;

  localparam int N  = 2;
  localparam int AW = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid, rsp_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, mem_data_in, mem_data_out;
  logic [AW-1:0]   mem_addr;
  logic            mem_enable;

  logic [DW-1:0]   tb_mem  [16];
  logic [DW-1:0]   ref_mem [16];

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state (written only by the monitor)
  int            m_state = 0;
  int            m_ptr   = N - 1;
  int            m_owner = 0;
  logic          m_wr    = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_data  = '0;
  logic          m_pend  = 1'b0;
  logic [DW-1:0] last_rdata = '0;
  logic [DW-1:0] sb[$];
  int            grant_log[$];

  mem_access_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid),
    .req_write_i    (req_write),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .req_ready_o    (req_ready),
    .rsp_valid_o    (rsp_valid),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_ready_i    (rsp_ready),
    .mem_enable_o   (mem_enable),
    .mem_addr_o     (mem_addr),
    .mem_data_in_o  (mem_data_in),
    .mem_data_out_i (mem_data_out)
  );

  always #5 clk = ~clk;

  // single-port memory: combinational read, write on rising edge
  assign mem_data_out = tb_mem[mem_addr];
  always @(posedge clk) if (mem_enable) tb_mem[mem_addr] <= mem_data_in;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] model_grant(input logic [N-1:0] v, input int p, output int idx);
    logic [N-1:0] g;
    g   = '0;
    idx = 0;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (p + k) % N;
      if (g == '0 && v[c]) begin
        g[c] = 1'b1;
        idx  = c;
      end
    end
    return g;
  endfunction

  // reference model + scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    logic [N-1:0] g;
    int gi;
    if (!rst_n) begin
      m_state = 0; m_ptr = N - 1; m_pend = 1'b0; sb.delete();
      check_val("rst_req_ready", DW'(req_ready), '0);
      check_val("rst_rsp_valid", DW'(rsp_valid), '0);
      check_val("rst_rsp_rdata", rsp_rdata, '0);
      check_val("rst_mem_en", DW'(mem_enable), '0);
      check_val("rst_mem_addr", DW'(mem_addr), '0);
      check_val("rst_mem_din", mem_data_in, '0);
    end else begin
      case (m_state)
        0: begin
          g = model_grant(req_valid, m_ptr, gi);
          check_val("req_ready", DW'(req_ready), DW'(g));
          check_val("idle_rsp_valid", DW'(rsp_valid), '0);
          check_val("idle_mem_en", DW'(mem_enable), '0);
          if (g != '0) begin
            m_owner = gi;
            m_wr    = req_write[gi];
            m_addr  = req_addr[gi*AW +: AW];
            m_data  = req_wdata[gi*DW +: DW];
            sb.push_back(m_wr ? '0 : ref_mem[m_addr]);
            grant_log.push_back(gi);
            m_ptr   = gi;
            m_state = 1;
          end
        end
        1: begin
          check_val("acc_mem_en", DW'(mem_enable), DW'(m_wr));
          check_val("acc_mem_addr", DW'(mem_addr), DW'(m_addr));
          check_val("acc_mem_din", mem_data_in, m_data);
          check_val("acc_req_ready", DW'(req_ready), '0);
          check_val("acc_rsp_valid", DW'(rsp_valid), '0);
          m_pend  = m_wr;
          m_state = 2;
        end
        default: begin
          if (m_pend) begin
            ref_mem[m_addr] = m_data;
            m_pend = 1'b0;
          end
          check_val("rsp_valid", DW'(rsp_valid), DW'(1 << m_owner));
          check_val("rsp_req_ready", DW'(req_ready), '0);
          check_val("rsp_mem_en", DW'(mem_enable), '0);
          check_val("rsp_mem_addr_hold", DW'(mem_addr), DW'(m_addr));
          if (sb.size() == 0) begin
            check_val("sb_underflow", DW'(sb.size()), 1);
          end else begin
            check_val("rsp_rdata", rsp_rdata, sb[0]);
            if (rsp_ready[m_owner]) begin
              last_rdata = sb.pop_front();
              m_state    = 0;
            end
          end
        end
      endcase
    end
  end

  // Present one request and hold it until accepted (bounded wait).
  task automatic send(input int id, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int  n;
    logic got;
    @(posedge clk); #1;
    req_write[id]            = wr;
    req_addr[id*AW +: AW]    = a;
    req_wdata[id*DW +: DW]   = d;
    req_valid[id]            = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      got = req_ready[id];
      n++;
    end while (!got && n < 100);
    if (!got) check_val("req_timeout", DW'(got), 1);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((m_state != 0 || sb.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (n >= 100) check_val("idle_timeout", DW'(m_state), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int exp_order[4];
    exp_order = '{0, 1, 0, 1};
    for (int i = 0; i < 16; i++) begin
      tb_mem[i]  = '0;
      ref_mem[i] = '0;
    end
    tb_mem[15]  = 32'hDEADBEEF;
    ref_mem[15] = 32'hDEADBEEF;
    rst_n = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    rsp_ready = '1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // write then read back on requester 0
    send(0, 1'b1, 4'd3, 32'h12345678);
    wait_idle();
    send(0, 1'b0, 4'd3, '0);
    wait_idle();
    check_val("wr_rd_data", last_rdata, 32'h12345678);

    // response back-pressure on requester 1
    rsp_ready[1] = 1'b0;
    send(1, 1'b0, 4'd3, '0);
    repeat (5) @(posedge clk);
    #1 rsp_ready[1] = 1'b1;
    wait_idle();

    // both requesters valid continuously: grants alternate
    grant_log.delete();
    fork
      begin send(0, 1'b1, 4'd7, 32'h0A0A0A0A); send(0, 1'b0, 4'd8, '0); end
      begin send(1, 1'b1, 4'd8, 32'hB1B1B1B1); send(1, 1'b0, 4'd7, '0); end
    join
    wait_idle();
    check_val("rr_count", DW'(grant_log.size()), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check_val("rr_order", DW'(grant_log[i]), DW'(exp_order[i]));

    // reset in the middle of a write access
    @(posedge clk); #1;
    req_write[0] = 1'b1; req_addr[0 +: AW] = 4'd5; req_wdata[0 +: DW] = 32'hAABBCCDD;
    req_valid[0] = 1'b1;
    @(negedge clk);
    check_val("rst_t_ready", DW'(req_ready[0]), 1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check_val("rst_t_mem_en_pre", DW'(mem_enable), 1);
    rst_n = 1'b0;
    #1;
    check_val("rst_t_mem_en", DW'(mem_enable), '0);
    check_val("rst_t_mem_addr", DW'(mem_addr), '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_val("rst_t_no_write", tb_mem[5], '0);
    send(0, 1'b0, 4'd5, '0);
    wait_idle();
    check_val("rst_t_readback", last_rdata, '0);

    // top address
    send(1, 1'b0, 4'd15, '0);
    wait_idle();
    check_val("addr15_data", last_rdata, 32'hDEADBEEF);
    check_val("sb_drained", DW'(sb.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mem_access_arbiter
`default_nettype wire
